// File: rtl/seq_det_param.sv
// seq_det_param
//   Parametrised serial pattern detector. Bits are shifted into a PAT_LEN-bit
//   history when in_valid is high; det_o pulses for one cycle after the edge
//   that sampled the final bit of PATTERN. PATTERN's MSB is the oldest bit.
//   With OVERLAP=1 a match suffix may begin the next match. With OVERLAP=0
//   the fill count restarts after each match, so the next match needs PAT_LEN
//   fresh valid bits.
//
//   Optional feature: define SEQ_DET_CNT_EN to add a saturating match counter
//   (match_cnt) with a synchronous clear (cnt_clr).
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   seq_in     in   serial data bit
//   in_valid   in   seq_in is sampled only when high
//   det_o      out  registered single-cycle detect pulse
//   cnt_clr    in   synchronous counter clear (SEQ_DET_CNT_EN only)
//   match_cnt  out  saturating match count, CNT_W bits (SEQ_DET_CNT_EN only)
module seq_det_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             in_valid,
  output logic             det_o
`ifdef SEQ_DET_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

  // Elaboration-time parameter sanity checks.
  if (PAT_LEN < 1 || PAT_LEN > 32) begin : g_bad_pat_len
    $error("seq_det_param: PAT_LEN must be in 1..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_det_param: CNT_W must be at least 1");
  end

  logic [PAT_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] hist_nxt;
  logic               match_p0;

  // History including the bit being sampled now. The cast drops the oldest
  // bit and also covers PAT_LEN=1, where the history is just seq_in.
  assign hist_nxt = PAT_LEN'({hist, seq_in});

  // fill counts bits already held, so PAT_LEN-1 held bits plus the incoming
  // one completes a window. This also blocks a false hit when the all-zero
  // reset history happens to equal PATTERN.
  assign match_p0 = in_valid && (fill >= FILL_LAST) && (hist_nxt == PATTERN);

  // ---- stage p0 -> p1: history/fill update and registered detect ----
  always_ff @(posedge clock) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      det_o <= 1'b0;
    end else begin
      det_o <= match_p0;
      if (in_valid) begin
        hist <= hist_nxt;
        if (!OVERLAP && match_p0) begin
          fill <= '0;
        end else if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over a simultaneous match; the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      match_cnt <= '0;
    end else if (match_p0 && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three instances (1011 overlapping, 1011
// non-overlapping, 0000 overlapping) share one stimulus stream; each is
// checked against hand-derived detect vectors. With SEQ_DET_CNT_EN defined a
// fourth instance with CNT_W=2 exercises the saturating counter.
module tb_seq_det_param;

  logic clock;
  logic reset;
  logic seq_in;
  logic in_valid;
  logic det_ov;
  logic det_nov;
  logic det_zero;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SEQ_DET_CNT_EN
  logic       cnt_clr;
  logic       det_cnt;
  logic [7:0] cnt_ov;
  logic [7:0] cnt_nov;
  logic [7:0] cnt_zero;
  logic [1:0] cnt_sat;
`endif

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_ov (
    .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .det_o(det_ov)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(cnt_ov)
`endif
  );

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_nov (
    .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .det_o(det_nov)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(cnt_nov)
`endif
  );

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) dut_zero (
    .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .det_o(det_zero)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(cnt_zero)
`endif
  );

`ifdef SEQ_DET_CNT_EN
  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_cnt (
    .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .det_o(det_cnt), .cnt_clr(cnt_clr), .match_cnt(cnt_sat)
  );
`endif

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    seq_in   = b;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Feed n valid bits (MSB of 'bits' first) and check each instance's det_o
  // against the matching bit of its expected vector.
  task automatic run_seq(input string name, input int n, input logic [31:0] bits,
                         input logic [31:0] e_ov, input logic [31:0] e_nov,
                         input logic [31:0] e_zero);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i]);
      check_val($sformatf("%s ov bit%0d", name, i + 1), int'(det_ov), int'(e_ov[n-1-i]));
      check_val($sformatf("%s nov bit%0d", name, i + 1), int'(det_nov), int'(e_nov[n-1-i]));
      check_val($sformatf("%s zero bit%0d", name, i + 1), int'(det_zero), int'(e_zero[n-1-i]));
    end
  endtask

  logic [3:0] gap_bits;

  initial begin
    clock    = 1'b0;
    reset    = 1'b1;
    seq_in   = 1'b0;
    in_valid = 1'b0;
    gap_bits = 4'b1011;
`ifdef SEQ_DET_CNT_EN
    cnt_clr  = 1'b0;
`endif

    // Reset state
    do_reset();
    check_val("reset ov", int'(det_ov), 0);
    check_val("reset nov", int'(det_nov), 0);
    check_val("reset zero", int'(det_zero), 0);

    // Stream 1011011: overlap hits at bits 4 and 7, non-overlap only at 4
    run_seq("s1", 7, 32'b1011011, 32'b0001001, 32'b0001000, 32'b0);

    // Stream 10111011: both modes hit at bits 4 and 8
    do_reset();
    run_seq("s2", 8, 32'b10111011, 32'b00010001, 32'b00010001, 32'b0);

    // Gapped input: three idle cycles (with junk on seq_in) after each bit
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gap_bits[3-i]);
      check_val($sformatf("gap ov bit%0d", i + 1), int'(det_ov), (i == 3) ? 1 : 0);
      check_val($sformatf("gap nov bit%0d", i + 1), int'(det_nov), (i == 3) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, ~gap_bits[3-i]);
        check_val($sformatf("gap ov idle%0d.%0d", i + 1, g), int'(det_ov), 0);
        check_val($sformatf("gap nov idle%0d.%0d", i + 1, g), int'(det_nov), 0);
      end
    end

    // Reset mid-pattern: 1,0,1 then reset on the edge carrying the final 1
    do_reset();
    run_seq("rst_pre", 3, 32'b101, 32'b0, 32'b0, 32'b0);
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    check_val("rst_edge ov", int'(det_ov), 0);
    check_val("rst_edge nov", int'(det_nov), 0);
    // 0,1,1 is only three bits; then 1,0,1,1 completes a fresh match
    run_seq("rst_post", 7, 32'b0111011, 32'b0000001, 32'b0000001, 32'b0);

    // All-zero pattern: reset history must not count as three held zeros
    do_reset();
    run_seq("zeros", 5, 32'b00000, 32'b0, 32'b0, 32'b00011);

`ifdef SEQ_DET_CNT_EN
    // Counter: five overlapping matches on a 2-bit counter -> 1,2,3,3,3
    do_reset();
    check_val("cnt reset", int'(cnt_sat), 0);
    for (int m = 0; m < 5; m++) begin
      if (m == 0) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check_val($sformatf("cnt det%0d", m + 1), int'(det_cnt), 1);
      check_val($sformatf("cnt val%0d", m + 1), int'(cnt_sat), (m < 3) ? m + 1 : 3);
    end
    // Clear on the same edge as a match: clear wins
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    cnt_clr = 1'b0;
    check_val("cnt clr det", int'(det_cnt), 1);
    check_val("cnt clr val", int'(cnt_sat), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("cnt after clr", int'(cnt_sat), 1);
    check_val("cnt ov 8b", int'(cnt_ov), 1);
    check_val("cnt nov 8b", int'(cnt_nov), 1);
    check_val("cnt zero 8b", int'(cnt_zero), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
